div_arbiter: RTL

DIV_ARBITER -- requirements
Module: div_arbiter

---
 rtl/div_pkg.sv | 14 +
 rtl/div_arbiter_rr_pick.sv | 29 ++
 rtl/div_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the divider arbiter: FSM state encoding and opcode values.
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic OP_UNSIGNED = 1'b0;
    localparam logic OP_SIGNED   = 1'b1;

endpackage

// File: rtl/div_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping around.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]                                 req,
    input  logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0]   ptr,
    output logic [NUM_REQ-1:0]                                 grant,
    output logic                                               any_req
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] pick;

    assign any_req = |req;

    // Walk the ring from farthest to nearest so the nearest hit wins
    always_comb begin
        pick  = '0;
        grant = '0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            if (req[PTR_W'((int'(ptr) + k) % int'(NUM_REQ))]) begin
                pick = PTR_W'((int'(ptr) + k) % int'(NUM_REQ));
            end
        end
        grant[pick] = any_req;
    end

endmodule

// File: rtl/div_arbiter.sv
// Arbitrates NUM_REQ requesters onto one shared integer divider, one divide in flight at a time.
module div_arbiter
    import div_pkg::*;
#(
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned NUM_REQ = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ-1:0]         req_opcode,
    input  logic [NUM_REQ*WIDTH-1:0]   req_dividend,
    input  logic [NUM_REQ*WIDTH-1:0]   req_divisor,
    output logic [NUM_REQ-1:0]         rsp_valid,
    input  logic [NUM_REQ-1:0]         rsp_ready,
    output logic [WIDTH-1:0]           rsp_quotient,
    output logic [WIDTH-1:0]           rsp_remainder,
    output logic                       div_valid_in,
    output logic                       div_opcode,
    output logic [WIDTH-1:0]           div_dividend,
    output logic [WIDTH-1:0]           div_divisor,
    input  logic                       div_valid_out,
    input  logic [WIDTH-1:0]           div_quotient,
    input  logic [WIDTH-1:0]           div_remainder,
    output logic                       busy
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t             state;
    state_t             state_next;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   grant_id;
    logic [PTR_W-1:0]   pick_id;
    logic [NUM_REQ-1:0] pick;
    logic               any_req;
    logic               accept;
    logic               rsp_fire;
    logic               sel_op;
    logic [WIDTH-1:0]   sel_dvd;
    logic [WIDTH-1:0]   sel_dvs;
    logic               op_q;
    logic [WIDTH-1:0]   dvd_q;
    logic [WIDTH-1:0]   dvs_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   rem_q;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req     (req_valid),
        .ptr     (ptr),
        .grant   (pick),
        .any_req (any_req)
    );

    // Operand mux for the one-hot winner
    always_comb begin
        pick_id = '0;
        sel_op  = OP_UNSIGNED;
        sel_dvd = '0;
        sel_dvs = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (pick[i]) begin
                pick_id = PTR_W'(i);
                sel_op  = req_opcode[i];
                sel_dvd = req_dividend[i*WIDTH +: WIDTH];
                sel_dvs = req_divisor[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Divide-by-zero skips the divider and goes straight to the response
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        rsp_fire   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_req && !reset) begin
                    accept     = 1'b1;
                    state_next = (sel_dvs == '0) ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT: begin
                if (div_valid_out) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready[grant_id]) begin
                    rsp_fire   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr      <= '0;
            grant_id <= '0;
            op_q     <= OP_UNSIGNED;
            dvd_q    <= '0;
            dvs_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
        end else begin
            if (accept) begin
                grant_id <= pick_id;
                op_q     <= sel_op;
                dvd_q    <= sel_dvd;
                dvs_q    <= sel_dvs;
                if (sel_dvs == '0) begin
                    quo_q <= '1;
                    rem_q <= sel_dvd;
                end
            end
            if ((state == ST_WAIT) && div_valid_out) begin
                quo_q <= div_quotient;
                rem_q <= div_remainder;
            end
            if (rsp_fire) begin
                ptr <= (grant_id == PTR_W'(NUM_REQ - 1)) ? '0 : grant_id + PTR_W'(1);
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (state == ST_RESP) begin
            rsp_valid[grant_id] = 1'b1;
        end
    end

    assign req_ready     = accept ? pick : '0;
    assign busy          = (state != ST_IDLE);
    assign div_valid_in  = (state == ST_ISSUE);
    assign div_opcode    = op_q;
    assign div_dividend  = dvd_q;
    assign div_divisor   = dvs_q;
    assign rsp_quotient  = quo_q;
    assign rsp_remainder = rem_q;

endmodule
